imm_ext_pipe: RTL and testbench

Pipelined, parametrised immediate-extension unit for the term-project datapath. It takes IN_W-bit instruction immediates and produces OUT_W-bit operands in one of four modes. It also supports a prefix mechanism: a prefix beat holds upper bits in a register, and the next immediate concatenates onto them. It sits between decode and the ALU operand mux, with a valid/ready handshake on both sides and a one-stage registered output.

---
 rtl/imm_ext_pipe_if.sv | 60 ++++++
 rtl/imm_ext_pipe.sv | 216 +++++++++++++++++++++
 tb/tb_imm_ext_pipe.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_ext_pipe_if.sv
// ---------------------------------------------------------------------------
// imm_ext_pipe_if
// Handshake bundle between decode (master) and the immediate-extension unit
// (slave).
//
// Parameters:
//   IN_W   immediate field width
//   OUT_W  extended operand width
//
// Signals:
//   in_valid / in_ready    input beat handshake
//   in_imm                 immediate field (IN_W bits)
//   in_mode                00 zero, 01 sign, 10 ones, 11 upper
//   in_pfx                 beat is a prefix load (produces no output)
//   out_valid / out_ready  output handshake
//   out_data               extended operand (OUT_W bits)
//   out_pfx_used           out_data was built from a held prefix
// ---------------------------------------------------------------------------
interface imm_ext_pipe_if #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             in_pfx;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_pfx_used;

  // Decode side: issues beats and consumes operands.
  modport master (
    output in_valid,
    output in_imm,
    output in_mode,
    output in_pfx,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_pfx_used
  );

  // Extension unit side.
  modport slave (
    input  in_valid,
    input  in_imm,
    input  in_mode,
    input  in_pfx,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_pfx_used
  );

endinterface

// File: rtl/imm_ext_pipe.sv
// ---------------------------------------------------------------------------
// imm_ext_pipe
// Pipelined immediate-extension unit. Extends IN_W-bit immediates to OUT_W
// bits in one of four modes, or concatenates them under a previously loaded
// prefix. One registered output stage with valid/ready on both sides.
//
// Parameters:
//   IN_W   immediate width (1 .. OUT_W-1)
//   OUT_W  operand width
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous discard of held prefix and output register
//   bus        imm_ext_pipe_if slave modport (handshake, data, mode)
//   ext_count  [IMMEXT_STATS_EN only] saturating count of non-prefix beats
//   pfx_count  [IMMEXT_STATS_EN only] saturating count of prefix-built outputs
//
// Optional feature macro: IMMEXT_STATS_EN adds the two statistics counters
// and their output ports. Without it the unit is otherwise identical.
// ---------------------------------------------------------------------------
module imm_ext_pipe #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  imm_ext_pipe_if.slave   bus
`ifdef IMMEXT_STATS_EN
  ,
  output logic [15:0]     ext_count,
  output logic [15:0]     pfx_count
`endif
);

  localparam int PFX_W = OUT_W - IN_W;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    PFX_HELD = 1'b1
  } state_t;

  // Mode-based extension used when no prefix is held.
  function automatic logic [OUT_W-1:0] extend_imm(
    input logic [IN_W-1:0] imm,
    input logic [1:0]      mode
  );
    logic [OUT_W-1:0] res;
    case (mode)
      2'b00:   res = {{PFX_W{1'b0}}, imm};
      2'b01:   res = {{PFX_W{imm[IN_W-1]}}, imm};
      2'b10:   res = {{PFX_W{1'b1}}, imm};
      2'b11:   res = {imm, {PFX_W{1'b0}}};
      default: res = {OUT_W{1'b0}};
    endcase
    return res;
  endfunction

  // Fit an immediate into the prefix register: zero-extend when the
  // immediate is narrower, keep the low PFX_W bits when it is wider.
  // Widening to OUT_W first covers both cases since PFX_W < OUT_W.
  function automatic logic [PFX_W-1:0] fit_prefix(
    input logic [IN_W-1:0] imm
  );
    logic [OUT_W-1:0] wide;
    wide = OUT_W'(imm);
    return wide[PFX_W-1:0];
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic [PFX_W-1:0]  pfx_r;
  logic [PFX_W-1:0]  pfx_nxt_s;
  logic              out_valid_r;
  logic              out_valid_nxt_s;
  logic [OUT_W-1:0]  out_data_r;
  logic [OUT_W-1:0]  out_data_nxt_s;
  logic              out_pfx_used_r;
  logic              out_pfx_used_nxt_s;
  logic [OUT_W-1:0]  ext_data_s;
  logic              ext_used_s;

  logic              in_ready_s;
  logic              accept_s;
  logic              pfx_load_s;
  logic              data_load_s;

  // A flush cycle still reports in_ready normally, but the beat is dropped,
  // so acceptance is masked with flush rather than in_ready.
  assign in_ready_s  = !out_valid_r || bus.out_ready;
  assign accept_s    = bus.in_valid && in_ready_s && !flush;
  assign pfx_load_s  = accept_s && bus.in_pfx;
  assign data_load_s = accept_s && !bus.in_pfx;

  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_data     = out_data_r;
  assign bus.out_pfx_used = out_pfx_used_r;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic: prefix beats enter/stay in PFX_HELD, a data beat
  // consumes the prefix, flush always returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = IDLE;
    end else if (pfx_load_s) begin
      state_nxt_s = PFX_HELD;
    end else if (data_load_s) begin
      state_nxt_s = IDLE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM output logic: operand formed for the current state.
  always_comb begin
    ext_data_s = {OUT_W{1'b0}};
    ext_used_s = 1'b0;
    case (state_r)
      IDLE: begin
        ext_data_s = extend_imm(bus.in_imm, bus.in_mode);
        ext_used_s = 1'b0;
      end
      PFX_HELD: begin
        // Mode is ignored when a prefix supplies the upper bits.
        ext_data_s = {pfx_r, bus.in_imm};
        ext_used_s = 1'b1;
      end
      default: begin
        ext_data_s = {OUT_W{1'b0}};
        ext_used_s = 1'b0;
      end
    endcase
  end

  // Next values for the prefix and output registers.
  always_comb begin
    pfx_nxt_s          = pfx_r;
    out_valid_nxt_s    = out_valid_r;
    out_data_nxt_s     = out_data_r;
    out_pfx_used_nxt_s = out_pfx_used_r;
    if (flush) begin
      pfx_nxt_s       = {PFX_W{1'b0}};
      out_valid_nxt_s = 1'b0;
    end else begin
      if (pfx_load_s) begin
        pfx_nxt_s = fit_prefix(bus.in_imm);
      end else begin
        pfx_nxt_s = pfx_r;
      end
      if (data_load_s) begin
        out_valid_nxt_s    = 1'b1;
        out_data_nxt_s     = ext_data_s;
        out_pfx_used_nxt_s = ext_used_s;
      end else if (bus.out_ready) begin
        // Consumer took the operand and nothing replaced it.
        out_valid_nxt_s = 1'b0;
      end else begin
        out_valid_nxt_s = out_valid_r;
      end
    end
  end

  // Prefix and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pfx_r          <= {PFX_W{1'b0}};
      out_valid_r    <= 1'b0;
      out_data_r     <= {OUT_W{1'b0}};
      out_pfx_used_r <= 1'b0;
    end else begin
      pfx_r          <= pfx_nxt_s;
      out_valid_r    <= out_valid_nxt_s;
      out_data_r     <= out_data_nxt_s;
      out_pfx_used_r <= out_pfx_used_nxt_s;
    end
  end

`ifdef IMMEXT_STATS_EN
  logic [15:0] ext_count_r;
  logic [15:0] pfx_count_r;

  // Saturating statistics counters; flush does not touch them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_count_r <= 16'h0000;
      pfx_count_r <= 16'h0000;
    end else begin
      if (data_load_s && (ext_count_r != 16'hFFFF)) begin
        ext_count_r <= ext_count_r + 16'h0001;
      end else begin
        ext_count_r <= ext_count_r;
      end
      if (data_load_s && ext_used_s && (pfx_count_r != 16'hFFFF)) begin
        pfx_count_r <= pfx_count_r + 16'h0001;
      end else begin
        pfx_count_r <= pfx_count_r;
      end
    end
  end

  assign ext_count = ext_count_r;
  assign pfx_count = pfx_count_r;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_ext_pipe
// Self-checking bench for imm_ext_pipe: directed literal expectations plus a
// randomized run compared every cycle against an arithmetic reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imm_ext_pipe;

  localparam int IW = 7;
  localparam int OW = 16;
  localparam int PW = OW - IW;

  logic clk;
  logic rst_n;
  logic flush;

  imm_ext_pipe_if #(.IN_W(IW), .OUT_W(OW)) bus ();

`ifdef IMMEXT_STATS_EN
  logic [15:0] ext_count;
  logic [15:0] pfx_count;
`endif

  imm_ext_pipe #(.IN_W(IW), .OUT_W(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
`ifdef IMMEXT_STATS_EN
    ,
    .ext_count (ext_count),
    .pfx_count (pfx_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_valid, m_data, m_used, m_held, m_pfx, m_ext, m_pcnt;

  function automatic int model_extend(input int imm, input int mode);
    case (mode)
      0:       return imm;
      1:       return (imm >= (1 << (IW-1))) ? imm + (1 << OW) - (1 << IW) : imm;
      2:       return imm + (1 << OW) - (1 << IW);
      default: return (imm * (1 << PW)) % (1 << OW);
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int acc;
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_used = 0; m_held = 0; m_pfx = 0;
      m_ext = 0; m_pcnt = 0;
    end else begin
      acc = (bus.in_valid && (m_valid == 0 || bus.out_ready)) ? 1 : 0;
      if (flush) begin
        m_valid = 0; m_held = 0; m_pfx = 0;
      end else begin
        if (bus.out_ready) m_valid = 0;
        if (acc == 1 && bus.in_pfx) begin
          m_held = 1;
          m_pfx  = int'(bus.in_imm) % (1 << PW);
        end else if (acc == 1) begin
          if (m_held == 1) begin
            m_data = m_pfx * (1 << IW) + int'(bus.in_imm);
            m_used = 1;
          end else begin
            m_data = model_extend(int'(bus.in_imm), int'(bus.in_mode));
            m_used = 0;
          end
          m_valid = 1;
          m_held  = 0;
          if (m_ext < 65535) m_ext++;
          if (m_used == 1 && m_pcnt < 65535) m_pcnt++;
        end
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("cyc_out_valid", int'(bus.out_valid), m_valid);
      if (m_valid == 1) begin
        chk("cyc_out_data", int'(bus.out_data), m_data);
        chk("cyc_out_pfx_used", int'(bus.out_pfx_used), m_used);
      end
      chk("cyc_in_ready", int'(bus.in_ready), (m_valid == 0 || bus.out_ready) ? 1 : 0);
`ifdef IMMEXT_STATS_EN
      chk("cyc_ext_count", int'(ext_count), m_ext);
      chk("cyc_pfx_count", int'(pfx_count), m_pcnt);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic p, input logic [1:0] m,
                       input logic [IW-1:0] imm, input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_pfx    = p;
    bus.in_mode   = m;
    bus.in_imm    = imm;
    bus.out_ready = ordy;
    flush         = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int data, input int used);
    chk({name, "_valid"}, int'(bus.out_valid), 1);
    chk({name, "_data"}, int'(bus.out_data), data);
    chk({name, "_used"}, int'(bus.out_pfx_used), used);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_pfx = 1'b0; bus.in_mode = 2'b00;
    bus.in_imm = 7'd0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_out_pfx_used", int'(bus.out_pfx_used), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
`ifdef IMMEXT_STATS_EN
    chk("stats_after_reset_ext", int'(ext_count), 0);
    chk("stats_after_reset_pfx", int'(pfx_count), 0);
`endif

    // Basic modes.
    drive(1'b1, 1'b0, 2'b00, 7'd50, 1'b1, 1'b0);
    expect_out("t1_zero50", 16'h0032, 0);
    drive(1'b1, 1'b0, 2'b01, 7'h7A, 1'b1, 1'b0);
    expect_out("t2_sign", 16'hFFFA, 0);
    drive(1'b1, 1'b0, 2'b10, 7'h7A, 1'b1, 1'b0);
    expect_out("t2_ones", 16'hFFFA, 0);
    drive(1'b1, 1'b0, 2'b00, 7'h7A, 1'b1, 1'b0);
    expect_out("t2_zero", 16'h007A, 0);
    drive(1'b1, 1'b0, 2'b11, 7'h32, 1'b1, 1'b0);
    expect_out("t2_upper", 16'h6400, 0);
`ifdef IMMEXT_STATS_EN
    chk("stats_five_beats", int'(ext_count), 5);
`endif

    // Prefix concatenation.
    drive(1'b1, 1'b1, 2'b00, 7'h55, 1'b1, 1'b0);
    chk("t3_pfx_no_output", int'(bus.out_valid), 0);
    drive(1'b1, 1'b0, 2'b01, 7'h12, 1'b1, 1'b0);
    expect_out("t3_pfx_concat", 16'h2A92, 1);
    drive(1'b1, 1'b0, 2'b00, 7'h12, 1'b1, 1'b0);
    expect_out("t3_after_pfx", 16'h0012, 0);

    // Backpressure: operand held, nothing accepted, queued beat follows.
    drive(1'b1, 1'b0, 2'b00, 7'h11, 1'b1, 1'b0);
    expect_out("t4_first", 16'h0011, 0);
    bus.in_imm = 7'h22; bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_stall_in_ready", int'(bus.in_ready), 0);
      expect_out("t4_stall_hold", 16'h0011, 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t4_release_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    expect_out("t4_queued", 16'h0022, 0);

    // Flush discards prefix and output.
    drive(1'b1, 1'b1, 2'b00, 7'h55, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 7'h00, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 2'b00, 7'h12, 1'b1, 1'b0);
    expect_out("t5_flushed_pfx", 16'h0012, 0);
    drive(1'b0, 1'b0, 2'b00, 7'h00, 1'b0, 1'b1);
    chk("t5_flush_clears_valid", int'(bus.out_valid), 0);
    drive(1'b1, 1'b0, 2'b00, 7'h33, 1'b1, 1'b1);
    chk("t5_flush_drops_beat", int'(bus.out_valid), 0);

    // Asynchronous reset with a valid operand in the output register.
    drive(1'b1, 1'b0, 2'b00, 7'h05, 1'b0, 1'b0);
    expect_out("t6_pre_reset", 16'h0005, 0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(bus.out_valid), 0);
    chk("t6_rst_data", int'(bus.out_data), 0);
    chk("t6_rst_used", int'(bus.out_pfx_used), 0);
`ifdef IMMEXT_STATS_EN
    chk("t6_rst_ext_count", int'(ext_count), 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // Asynchronous reset while a prefix is held: it must not survive.
    drive(1'b1, 1'b1, 2'b00, 7'h55, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 2'b00, 7'h12, 1'b1, 1'b0);
    expect_out("t6_no_stale_pfx", 16'h0012, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)),
            7'($urandom_range(0, 127)),
            ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end

    drive(1'b0, 1'b0, 2'b00, 7'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
